// File: rtl/game_engine.sv
// game_engine: player sprite tracker for the VGA grid.
// Per frame it erases the old sprite, moves one step, checks ghost overlaps,
// updates score/lives and redraws the sprite as an x/y/colour/plot stream.
// Optional feature macro: GAME_GHOST_EAT_EN (edible ghosts score and pulse
// ghost_eaten; without it every overlapping ghost is lethal).
`timescale 1ns/1ps
module game_engine #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int NUM_GHOSTS = 4,
    parameter int SPRITE     = 4,
    parameter int MOVE_TICKS = 1000000,
    parameter int SCORE_W    = 4,
    parameter int LIVES      = 3,
    parameter int X_START    = 80,
    parameter int Y_START    = 60,
    parameter int X_MAX      = 156,
    parameter int Y_MAX      = 116
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_game,
    input  logic [1:0]                direction,
    input  logic                      touching_wall,
    input  logic                      pellet_hit,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
    input  logic [NUM_GHOSTS-1:0]     ghost_bad,
    output logic [X_W-1:0]            x,
    output logic [Y_W-1:0]            y,
    output logic [2:0]                plot_color,
    output logic                      plot,
    output logic [1:0]                s_screen,
    output logic                      s_game_over,
    output logic [SCORE_W-1:0]        score,
    output logic [2:0]                lives,
    output logic [NUM_GHOSTS-1:0]     ghost_eaten
);

    localparam int TW = (MOVE_TICKS > 2) ? $clog2(MOVE_TICKS) : 1;
    localparam int CW = $clog2(NUM_GHOSTS + 2);
    localparam int SW = SCORE_W + CW;

    localparam logic [TW-1:0]        T_LAST = TW'(MOVE_TICKS - 1);
    localparam logic [X_W-1:0]       XS     = X_W'(X_START);
    localparam logic [Y_W-1:0]       YS     = Y_W'(Y_START);
    localparam logic [X_W-1:0]       XM     = X_W'(X_MAX);
    localparam logic [Y_W-1:0]       YM     = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]       CX_END = X_W'(SPRITE - 1);
    localparam logic [Y_W-1:0]       CY_END = Y_W'(SPRITE - 1);
    localparam logic signed [X_W:0]  SP_X   = (X_W+1)'(SPRITE);
    localparam logic signed [Y_W:0]  SP_Y   = (Y_W+1)'(SPRITE);
    localparam logic [SW-1:0]        SAT    = SW'((1 << SCORE_W) - 1);
    localparam logic [2:0]           COL_BG = 3'b000;
    localparam logic [2:0]           COL_PL = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ERASE, ST_MOVE, ST_CHECK, ST_HIT, ST_DRAW, ST_WAIT, ST_GAME_OVER
    } state_t;

    state_t                state_r;
    logic [X_W-1:0]        px_r;
    logic [Y_W-1:0]        py_r;
    logic [X_W-1:0]        cx_r;
    logic [Y_W-1:0]        cy_r;
    logic [TW-1:0]         timer_r;
    logic                  start_d_r;

    logic                  start_rise_s;
    logic                  last_pix_s;
    logic [X_W-1:0]        cx_nx_s;
    logic [Y_W-1:0]        cy_nx_s;
    logic [X_W-1:0]        nx_px_s;
    logic [Y_W-1:0]        nx_py_s;
    logic [NUM_GHOSTS-1:0] ov_s;
    logic [NUM_GHOSTS-1:0] eff_bad_s;
    logic [NUM_GHOSTS-1:0] eat_s;
    logic                  hit_bad_s;
    logic [CW-1:0]         eat_cnt_s;
    logic [SW-1:0]         sum_s;
    logic [SCORE_W-1:0]    score_nx_s;

    assign start_rise_s = start_game & ~start_d_r;
    assign last_pix_s   = (cx_r == CX_END) && (cy_r == CY_END);

    // Overlap test per ghost using one-bit-wider signed differences.
    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ov
        logic signed [X_W:0] dx_s;
        logic signed [Y_W:0] dy_s;
        assign dx_s    = $signed({1'b0, px_r}) - $signed({1'b0, ghost_x[g*X_W +: X_W]});
        assign dy_s    = $signed({1'b0, py_r}) - $signed({1'b0, ghost_y[g*Y_W +: Y_W]});
        assign ov_s[g] = (dx_s < SP_X) && (dx_s > -SP_X) && (dy_s < SP_Y) && (dy_s > -SP_Y);
    end

`ifdef GAME_GHOST_EAT_EN
    assign eff_bad_s = ghost_bad;
`else
    // Every ghost is lethal; ghost_bad is folded in only to keep it connected.
    assign eff_bad_s = ghost_bad | {NUM_GHOSTS{1'b1}};
`endif

    assign hit_bad_s = |(ov_s & eff_bad_s);
    assign eat_s     = ov_s & ~eff_bad_s;

    // Next raster offset inside the sprite square (column fastest).
    always_comb begin
        if (cx_r == CX_END) begin
            cx_nx_s = '0;
            cy_nx_s = cy_r + Y_W'(1);
        end else begin
            cx_nx_s = cx_r + X_W'(1);
            cy_nx_s = cy_r;
        end
    end

    // One-step move with wall stop and grid clamping.
    always_comb begin
        nx_px_s = px_r;
        nx_py_s = py_r;
        if (!touching_wall) begin
            case (direction)
                2'b00:   if (py_r != '0) nx_py_s = py_r - Y_W'(1); else nx_py_s = py_r;
                2'b01:   if (py_r < YM)  nx_py_s = py_r + Y_W'(1); else nx_py_s = py_r;
                2'b10:   if (px_r != '0) nx_px_s = px_r - X_W'(1); else nx_px_s = px_r;
                2'b11:   if (px_r < XM)  nx_px_s = px_r + X_W'(1); else nx_px_s = px_r;
                default: nx_px_s = px_r;
            endcase
        end else begin
            nx_px_s = px_r;
            nx_py_s = py_r;
        end
    end

    // Count of edible ghosts under the player this frame.
    always_comb begin
        eat_cnt_s = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            eat_cnt_s = eat_cnt_s + CW'(eat_s[i]);
        end
    end

    // Saturating score update.
    always_comb begin
        sum_s = SW'(score) + SW'(pellet_hit) + SW'(eat_cnt_s);
        if (sum_s > SAT) begin
            score_nx_s = {SCORE_W{1'b1}};
        end else begin
            score_nx_s = sum_s[SCORE_W-1:0];
        end
    end

    // Game FSM with frame timer and registered pixel stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            px_r        <= XS;
            py_r        <= YS;
            cx_r        <= '0;
            cy_r        <= '0;
            timer_r     <= '0;
            start_d_r   <= 1'b0;
            x           <= '0;
            y           <= '0;
            plot_color  <= 3'b000;
            plot        <= 1'b0;
            s_screen    <= 2'd0;
            s_game_over <= 1'b0;
            score       <= '0;
            lives       <= 3'(LIVES);
            ghost_eaten <= '0;
        end else begin
            start_d_r   <= start_game;
            ghost_eaten <= '0;
            if (timer_r != T_LAST) timer_r <= timer_r + TW'(1);
            else                   timer_r <= timer_r;
            case (state_r)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start_rise_s) begin
                        score       <= '0;
                        lives       <= 3'(LIVES);
                        s_screen    <= 2'd1;
                        s_game_over <= 1'b0;
                        px_r        <= XS;
                        py_r        <= YS;
                        x           <= XS;
                        y           <= YS;
                        cx_r        <= '0;
                        cy_r        <= '0;
                        plot        <= 1'b1;
                        plot_color  <= COL_PL;
                        timer_r     <= '0;
                        state_r     <= ST_DRAW;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_ERASE, ST_DRAW: begin
                    if (last_pix_s) begin
                        plot    <= 1'b0;
                        state_r <= (state_r == ST_ERASE) ? ST_MOVE : ST_WAIT;
                    end else begin
                        cx_r <= cx_nx_s;
                        cy_r <= cy_nx_s;
                        x    <= px_r + cx_nx_s;
                        y    <= py_r + cy_nx_s;
                    end
                end
                ST_MOVE: begin
                    px_r    <= nx_px_s;
                    py_r    <= nx_py_s;
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (hit_bad_s) begin
                        state_r <= ST_HIT;
                    end else begin
                        score       <= score_nx_s;
                        ghost_eaten <= eat_s;
                        x           <= px_r;
                        y           <= py_r;
                        cx_r        <= '0;
                        cy_r        <= '0;
                        plot        <= 1'b1;
                        plot_color  <= COL_PL;
                        state_r     <= ST_DRAW;
                    end
                end
                ST_HIT: begin
                    lives <= lives - 3'd1;
                    if (lives == 3'd1) begin
                        s_screen    <= 2'd2;
                        s_game_over <= 1'b1;
                        state_r     <= ST_GAME_OVER;
                    end else begin
                        px_r       <= XS;
                        py_r       <= YS;
                        x          <= XS;
                        y          <= YS;
                        cx_r       <= '0;
                        cy_r       <= '0;
                        plot       <= 1'b1;
                        plot_color <= COL_PL;
                        timer_r    <= '0;
                        state_r    <= ST_DRAW;
                    end
                end
                ST_WAIT: begin
                    if (timer_r == T_LAST) begin
                        x          <= px_r;
                        y          <= py_r;
                        cx_r       <= '0;
                        cy_r       <= '0;
                        plot       <= 1'b1;
                        plot_color <= COL_BG;
                        timer_r    <= '0;
                        state_r    <= ST_ERASE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    plot    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
